fp_exp_combine: RTL and testbench

FP_EXP_COMBINE -- requirements
Module: fp_exp_combine

---
 rtl/fp_exp_combine.sv | 103 ++++++++++
 tb/tb_fp_exp_combine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_exp_combine.sv
// fp_exp_combine: 2-stage FP16 multiplier joining the two partial exponentials into exp(a).
// Define FP_EXP_OVF_CNT_EN to add the saturating ovf_count port.
module fp_exp_combine #(
   parameter int PIPE_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] partial_exp1,
   input  logic [15:0] partial_exp2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] exp_out
`ifdef FP_EXP_OVF_CNT_EN
   ,output logic [15:0] ovf_count
`endif
);
   generate
      if (PIPE_STAGES != 2) begin : g_bad_stages
         $error("fp_exp_combine supports only PIPE_STAGES = 2");
      end
   endgenerate
   logic               s1_valid, s2_valid, s1_zero, s1_inf, s1_sign;
   logic [21:0]        s1_prod;
   logic signed [6:0]  s1_exp;
   logic [15:0]        s2_res;
   logic               in_fire, s2_adv;
   logic [4:0]         e1, e2;
   logic               op_zero, op_inf;
   logic [21:0]        prod;
   logic signed [6:0]  exp_sum;
   logic               hi, guard, sticky, round_up;
   logic [9:0]         mant;
   logic [10:0]        rnd;
   logic signed [6:0]  e_fin;
   logic [15:0]        res;
   assign s2_adv    = s1_valid && (!s2_valid || out_ready);
   assign in_ready  = !s1_valid || s2_adv;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign exp_out   = s2_res;
   // Stage 1: classify operands, multiply hidden-bit mantissas, sum biased exponents.
   assign e1      = partial_exp1[14:10];
   assign e2      = partial_exp2[14:10];
   assign op_zero = (e1 == 5'd0) || (e2 == 5'd0);
   assign op_inf  = (e1 == 5'h1f) || (e2 == 5'h1f);
   assign prod    = 22'({1'b1, partial_exp1[9:0]}) * 22'({1'b1, partial_exp2[9:0]});
   assign exp_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 7'sd15;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_zero  <= 1'b0;
         s1_inf   <= 1'b0;
         s1_sign  <= 1'b0;
         s1_prod  <= '0;
         s1_exp   <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_zero  <= op_zero;
            s1_inf   <= op_inf;
            s1_sign  <= partial_exp1[15] ^ partial_exp2[15];
            s1_prod  <= prod;
            s1_exp   <= exp_sum;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end
   // Stage 2: normalize, round to nearest even, then clamp to inf / zero.
   assign hi       = s1_prod[21];
   assign mant     = hi ? s1_prod[20:11] : s1_prod[19:10];
   assign guard    = hi ? s1_prod[10] : s1_prod[9];
   assign sticky   = hi ? |s1_prod[9:0] : |s1_prod[8:0];
   assign round_up = guard && (sticky || mant[0]);
   assign rnd      = {1'b0, mant} + {10'd0, round_up};
   assign e_fin    = s1_exp + (hi ? 7'sd1 : 7'sd0) + (rnd[10] ? 7'sd1 : 7'sd0);
   assign res      = s1_zero         ? 16'h0000 :
                     s1_inf          ? 16'h7C00 :
                     (e_fin >= 7'sd31) ? {s1_sign, 15'h7C00} :
                     (e_fin <= 7'sd0)  ? {s1_sign, 15'h0000} :
                                         {s1_sign, e_fin[4:0], rnd[9:0]};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_res   <= 16'h0000;
      end else if (s2_adv) begin
         s2_valid <= 1'b1;
         s2_res   <= res;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end
`ifdef FP_EXP_OVF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_count <= 16'h0000;
      else if (out_valid && out_ready && exp_out[14:10] == 5'h1f && ovf_count != 16'hFFFF)
         ovf_count <= ovf_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_fp_exp_combine.sv
// tb_fp_exp_combine: randomized and directed checks of fp_exp_combine against an arithmetic FP16 model.
module tb_fp_exp_combine;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] partial_exp1, partial_exp2, exp_out;
`ifdef FP_EXP_OVF_CNT_EN
   logic [15:0] ovf_count;
`endif
   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] q[$];
   logic        hold_pend = 1'b0;
   logic [15:0] hold_val;
   int          ovf_m = 0;

   fp_exp_combine #(.PIPE_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .partial_exp1(partial_exp1), .partial_exp2(partial_exp2),
      .out_valid(out_valid), .out_ready(out_ready),
      .exp_out(exp_out)
`ifdef FP_EXP_OVF_CNT_EN
      ,.ovf_count(ovf_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   // Exact product scaled to integers, rounded by comparing the discarded remainder against half an ulp.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, e, p, sh, qm, r, half;
      logic s;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      s  = a[15] ^ b[15];
      if (ea == 0 || eb == 0) return 16'h0000;
      if (ea == 31 || eb == 31) return 16'h7C00;
      p  = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
      e  = ea + eb - 15;
      sh = 10;
      if (p >= (1 << 21)) begin
         sh = 11;
         e++;
      end
      qm   = p >> sh;
      r    = p - (qm << sh);
      half = 1 << (sh - 1);
      if (r > half || (r == half && qm % 2 == 1)) qm++;
      if (qm == 2048) begin
         qm = 1024;
         e++;
      end
      if (e >= 31) return {s, 15'h7C00};
      if (e <= 0) return {s, 15'h0000};
      return {s, 5'(e), 10'(qm - 1024)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [4:0] ex;
      int k;
      k  = int'($urandom_range(0, 19));
      ex = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : (k == 2) ? 5'(28 + $urandom_range(0, 2)) :
           (k == 3) ? 5'(1 + $urandom_range(0, 3)) : 5'(8 + $urandom_range(0, 14));
      return {1'($urandom_range(0, 1)), ex, 10'($urandom)};
   endfunction

   // One clock cycle: drive at the falling edge, then check everything that the coming rising edge will act on.
   task automatic tick(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic ordy);
      logic [15:0] want;
      @(negedge clk);
      in_valid = iv;
      partial_exp1 = a;
      partial_exp2 = b;
      out_ready = ordy;
      #1;
`ifdef FP_EXP_OVF_CNT_EN
      check("ovf_count", ovf_count, 16'(ovf_m));
`endif
      if (hold_pend) check("hold_stable", exp_out, hold_val);
      hold_pend = 1'b0;
      check("in_ready", 16'(in_ready), 16'(q.size() < 2 || ordy));
      if (out_valid) begin
         if (q.size() == 0) check("spurious_valid", 16'(out_valid), 16'd0);
         else if (ordy) begin
            want = q.pop_front();
            check("exp_out", exp_out, want);
            if (want[14:10] == 5'h1f && ovf_m < 65535) ovf_m++;
         end else begin
            hold_pend = 1'b1;
            hold_val = exp_out;
         end
      end
      if (iv && in_ready) q.push_back(model(a, b));
   endtask

   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want);
      tick(1'b1, a, b, 1'b1);
      check("dir_accept", 16'(in_ready), 16'd1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("lat_t1", 16'(out_valid), 16'd0);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("lat_t2", 16'(out_valid), 16'd1);
      check("dir_value", exp_out, want);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("drain_empty", 16'(q.size()), 16'd0);
   endtask

   initial begin
      int sent;
      logic [15:0] pa[5];
      logic [15:0] pb[5];
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      partial_exp1 = 16'h0;
      partial_exp2 = 16'h0;
      #1;
      check("reset_valid", 16'(out_valid), 16'd0);
      check("reset_exp", exp_out, 16'h0000);
`ifdef FP_EXP_OVF_CNT_EN
      check("reset_ovf", ovf_count, 16'h0000);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      send_one(16'h3C00, 16'h3C00, 16'h3C00);
      send_one(16'h4000, 16'h3E00, 16'h4200);
      send_one(16'h3C01, 16'h3C01, 16'h3C02);
      send_one(16'h3C00, 16'h3BFF, 16'h3BFF);
      send_one(16'h7BFF, 16'h7BFF, 16'h7C00);
`ifdef FP_EXP_OVF_CNT_EN
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("ovf_first", ovf_count, 16'h0001);
`endif
      send_one(16'h7C00, 16'h3C00, 16'h7C00);
      send_one(16'h0000, 16'h7C00, 16'h0000);
      send_one(16'h0400, 16'h0400, 16'h0000);
      send_one(16'hBC00, 16'h3C00, 16'hBC00);
      send_one(16'hFBFF, 16'h7BFF, 16'hFC00);
      send_one(16'h8400, 16'h0400, 16'h8000);
      // Backpressure: consumer stalls for cycles 2..5 of a 5-pair burst.
      for (int i = 0; i < 5; i++) begin
         pa[i] = 16'h3C00 + 16'(i * 17);
         pb[i] = 16'h4000 + 16'(i * 33);
      end
      sent = 0;
      for (int c = 0; c < 16; c++) begin
         tick(sent < 5, pa[sent % 5], pb[sent % 5], !(c >= 2 && c <= 5));
         if (c == 3) check("bp_stall", 16'(in_ready), 16'd0);
         if (sent < 5 && in_ready) sent++;
      end
      check("bp_sent", 16'(sent), 16'd5);
      drain();
      // Reset with two pairs in flight.
      tick(1'b1, 16'h4400, 16'h4400, 1'b0);
      tick(1'b1, 16'h4800, 16'h3C00, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_valid", 16'(out_valid), 16'd0);
      check("midrst_exp", exp_out, 16'h0000);
      q.delete();
      hold_pend = 1'b0;
      ovf_m = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 16'h0, 1'b1);
      send_one(16'h4200, 16'h4000, 16'h4600);
      // Random traffic.
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 3) != 0);
      drain();
`ifdef FP_EXP_OVF_CNT_EN
      for (int i = 0; i < 65540; i++) tick(1'b1, 16'h7BFF, 16'h7BFF, 1'b1);
      drain();
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("ovf_saturated", ovf_count, 16'hFFFF);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
